// File: rtl/clb_cfg_pkg.sv
// Shared constants, frame layout and state encoding for the CLB configuration loader.
// CLB_CFG_PARITY_EN (optional) adds one even-parity bit after each frame.
package clb_cfg_pkg;

    localparam int FRAME_W = 37;
    localparam int LEN_W   = 8;
    localparam int CNT_W   = 6;

    localparam logic [3:0] PREAMBLE = 4'b0010;

    localparam int MEM_LSB    = 21;
    localparam int MEM_W      = 16;
    localparam int COMB_LSB   = 19;
    localparam int COMB_W     = 2;
    localparam int O2M_LSB    = 13;
    localparam int O2M_W      = 6;
    localparam int DQMUX_LSB  = 11;
    localparam int DQMUX_W    = 2;
    localparam int FOL_BIT    = 10;
    localparam int MUXSEL_LSB = 0;
    localparam int MUXSEL_W   = 10;

    // mem | comboption | o2m_0 o2m_1 | DQmux | floporlatch | mux2..mux6
    localparam logic [FRAME_W-1:0] DEFAULT_FRAME = {
        16'h0116, 2'b00, 3'b000, 3'b111, 2'b00, 1'b0, 10'b10_10_10_00_00
    };

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HUNT   = 3'd1,
        ST_LEN    = 3'd2,
        ST_FRAME  = 3'd3,
        ST_PAR    = 3'd4,
        ST_STOP   = 3'd5,
        ST_COMMIT = 3'd6,
        ST_ERR    = 3'd7
    } clb_cfg_state_e;

endpackage

// File: rtl/clb_cfg_loader_if.sv
// Serial-in / parallel-out bus between the configuration pin side and the loader.
// master drives the bitstream, slave is the loader.
interface clb_cfg_loader_if
    import clb_cfg_pkg::*;
#(
    parameter int NCLB = 4
);
    logic                      START;
    logic                      DIN;
    logic                      VALID;
    logic [NCLB*FRAME_W-1:0]   CFG;
    logic                      BUSY;
    logic                      DONE;
    logic                      ERR;

    modport master (
        output START, DIN, VALID,
        input  CFG, BUSY, DONE, ERR
    );

    modport slave (
        input  START, DIN, VALID,
        output CFG, BUSY, DONE, ERR
    );
endinterface

// File: rtl/clb_cfg_deser.sv
// MSB-first deserializer with a wrapping bit counter and running parity.
// The parity accumulator exists only when CLB_CFG_PARITY_EN is defined.
module clb_cfg_deser
    import clb_cfg_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_shift,
    input  logic               i_clr,
    input  logic               i_din,
    input  logic [CNT_W-1:0]   i_last,
    output logic [FRAME_W-1:0] o_word,
    output logic               o_done
`ifdef CLB_CFG_PARITY_EN
    ,
    output logic               o_par
`endif
);

    logic [FRAME_W-2:0] r_data;
    logic [CNT_W-1:0]   r_cnt;

    // o_word already includes the bit being accepted this edge
    assign o_word = {r_data, i_din};
    assign o_done = i_shift && (r_cnt == i_last);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_shift) begin
                r_data <= o_word[FRAME_W-2:0];
            end
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_shift) begin
                r_cnt <= o_done ? '0 : r_cnt + 1'b1;
            end
        end
    end

`ifdef CLB_CFG_PARITY_EN
    logic r_par;

    assign o_par = r_par;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_par <= 1'b0;
        end else if (i_clr) begin
            r_par <= 1'b0;
        end else if (i_shift) begin
            r_par <= r_par ^ i_din;
        end
    end
`endif

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial configuration loader: preamble hunt, length check, per-CLB frames, atomic commit.
// IDLE wait START | HUNT find preamble | LEN length | FRAME data | PAR parity (CLB_CFG_PARITY_EN)
// STOP stop bit | COMMIT copy shadow to CFG | ERR abort, CFG kept
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int NCLB = 4
) (
    input logic             K,
    input logic             RST,
    clb_cfg_loader_if.slave bus
);

    localparam int FCW = $clog2(NCLB + 1);

    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_HUNT   = 3'(ST_HUNT);
    localparam logic [2:0] S_LEN    = 3'(ST_LEN);
    localparam logic [2:0] S_FRAME  = 3'(ST_FRAME);
`ifdef CLB_CFG_PARITY_EN
    localparam logic [2:0] S_PAR    = 3'(ST_PAR);
`endif
    localparam logic [2:0] S_STOP   = 3'(ST_STOP);
    localparam logic [2:0] S_COMMIT = 3'(ST_COMMIT);
    localparam logic [2:0] S_ERR    = 3'(ST_ERR);

    logic [2:0]              r_state;
    logic [3:0]              r_win;
    logic [FCW-1:0]          r_fidx;
    logic [FRAME_W-1:0]      r_shadow [NCLB];
    logic [NCLB*FRAME_W-1:0] r_cfg;
    logic                    r_done;
    logic                    r_err;

    logic                    w_shift;
    logic                    w_clr;
    logic                    w_word_done;
    logic [FRAME_W-1:0]      w_word;
    logic [CNT_W-1:0]        w_last;
    logic [3:0]              w_win_next;
    logic [NCLB*FRAME_W-1:0] w_shadow_flat;
`ifdef CLB_CFG_PARITY_EN
    logic                    w_par;
`endif

    always_comb begin
        w_shift    = bus.VALID && (r_state == S_LEN || r_state == S_FRAME);
        w_last     = (r_state == S_LEN) ? CNT_W'(LEN_W - 1) : CNT_W'(FRAME_W - 1);
        w_win_next = {r_win[2:0], bus.DIN};
        // counter and parity restart at each frame boundary
        w_clr      = (r_state == S_IDLE && bus.START)
                  || (r_state == S_LEN  && w_word_done)
                  || (r_state == S_STOP && bus.VALID && bus.DIN);
    end

    always_comb begin
        w_shadow_flat = '0;
        for (int i = 0; i < NCLB; i++) begin
            w_shadow_flat[i*FRAME_W +: FRAME_W] = r_shadow[i];
        end
    end

    clb_cfg_deser u_deser (
        .i_clk   (K),
        .i_rst   (RST),
        .i_shift (w_shift),
        .i_clr   (w_clr),
        .i_din   (bus.DIN),
        .i_last  (w_last),
        .o_word  (w_word),
        .o_done  (w_word_done)
`ifdef CLB_CFG_PARITY_EN
        ,
        .o_par   (w_par)
`endif
    );

    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            r_fidx  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cfg   <= {NCLB{DEFAULT_FRAME}};
            for (int i = 0; i < NCLB; i++) begin
                r_shadow[i] <= DEFAULT_FRAME;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_state <= S_HUNT;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_win   <= 4'b1111;
                        r_fidx  <= '0;
                    end
                end
                S_HUNT: begin
                    if (bus.VALID) begin
                        r_win <= w_win_next;
                        if (w_win_next == PREAMBLE) begin
                            r_state <= S_LEN;
                        end
                    end
                end
                S_LEN: begin
                    if (w_word_done) begin
                        r_state <= (w_word[LEN_W-1:0] == LEN_W'(NCLB)) ? S_FRAME : S_ERR;
                    end
                end
                S_FRAME: begin
                    if (w_word_done) begin
                        for (int i = 0; i < NCLB; i++) begin
                            if (r_fidx == FCW'(i)) begin
                                r_shadow[i] <= w_word;
                            end
                        end
`ifdef CLB_CFG_PARITY_EN
                        r_state <= S_PAR;
`else
                        r_state <= S_STOP;
`endif
                    end
                end
`ifdef CLB_CFG_PARITY_EN
                S_PAR: begin
                    if (bus.VALID) begin
                        r_state <= (bus.DIN == w_par) ? S_STOP : S_ERR;
                    end
                end
`endif
                S_STOP: begin
                    if (bus.VALID) begin
                        if (!bus.DIN) begin
                            r_state <= S_ERR;
                        end else if (r_fidx == FCW'(NCLB - 1)) begin
                            r_state <= S_COMMIT;
                        end else begin
                            r_fidx  <= r_fidx + 1'b1;
                            r_state <= S_FRAME;
                        end
                    end
                end
                S_COMMIT: begin
                    r_cfg   <= w_shadow_flat;
                    r_done  <= 1'b1;
                    r_fidx  <= '0;
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_err   <= 1'b1;
                    r_fidx  <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.CFG  = r_cfg;
    assign bus.BUSY = (r_state != S_IDLE);
    assign bus.DONE = r_done;
    assign bus.ERR  = r_err;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed bench for clb_cfg_loader with NCLB=2; parity scenario runs when CLB_CFG_PARITY_EN is defined.
module tb_clb_cfg_loader;
    import clb_cfg_pkg::*;

    localparam int NCLB = 2;
`ifdef CLB_CFG_PARITY_EN
    localparam int FT = FRAME_W + 2;
`else
    localparam int FT = FRAME_W + 1;
`endif
    localparam int MIN_LAT = 1 + 4 + LEN_W + NCLB * FT + 1;

    localparam logic [36:0] DEF_F = {16'h0116, 2'b00, 3'b000, 3'b111, 2'b00, 1'b0,
                                     2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    localparam logic [73:0] DEF2 = {DEF_F, DEF_F};
    localparam logic [36:0] FA = 37'h123456789;
    localparam logic [36:0] FB = 37'h0FEDCBA98;
    localparam logic [36:0] FC = 37'h155555555;
    localparam logic [36:0] FD = 37'h0AAAAAAAA;

    logic K = 1'b0;
    logic RST;
    int   passed = 0;
    int   total  = 0;
    bit   q[$];

    clb_cfg_loader_if #(.NCLB(NCLB)) bus ();

    clb_cfg_loader #(.NCLB(NCLB)) dut (
        .K   (K),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 K = ~K;

    task automatic step();
        @(posedge K);
        #1;
    endtask

    task automatic build(input int fill, input logic [7:0] len, input logic [36:0] f0,
                         input logic [36:0] f1, input logic s0, input logic s1, input logic pbad);
        logic [3:0] pre;
        pre = PREAMBLE;
        q.delete();
        repeat (fill) q.push_back(1'b1);
        for (int i = 3; i >= 0; i--) q.push_back(pre[i]);
        for (int i = 7; i >= 0; i--) q.push_back(len[i]);
        for (int i = 36; i >= 0; i--) q.push_back(f0[i]);
`ifdef CLB_CFG_PARITY_EN
        q.push_back((^f0) ^ pbad);
`endif
        q.push_back(s0);
        for (int i = 36; i >= 0; i--) q.push_back(f1[i]);
`ifdef CLB_CFG_PARITY_EN
        q.push_back(^f1);
`endif
        q.push_back(s1);
    endtask

    // START, send q (optional gaps, optional START pulse at bit start_at), wait for DONE/ERR
    task automatic load(input int gap_en, input int start_at, output int lat, output int gaps,
                        output logic busy_s, output logic err_s);
        lat  = 0;
        gaps = 0;
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        lat++;
        busy_s = bus.BUSY;
        err_s  = bus.ERR;
        foreach (q[i]) begin
            if (gap_en != 0 && $urandom_range(0, 2) == 0) begin
                bus.VALID = 1'b0;
                bus.DIN   = 1'($urandom_range(0, 1));
                step();
                lat++;
                gaps++;
            end
            bus.VALID = 1'b1;
            bus.DIN   = q[i];
            if (i == start_at) bus.START = 1'b1;
            step();
            lat++;
            bus.START = 1'b0;
            bus.VALID = 1'b0;
        end
        for (int n = 0; n < 8 && !(bus.DONE || bus.ERR); n++) begin
            step();
            lat++;
        end
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.START = 1'b0;
        bus.VALID = 1'b0;
        bus.DIN   = 1'b0;
        step();
        step();
        total++; if (bus.CFG !== DEF2) $display("FAIL reset_cfg got=%h exp=%h", bus.CFG, DEF2); else passed++;
        total++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.BUSY); else passed++;
        total++; if (bus.DONE !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.DONE); else passed++;
        total++; if (bus.ERR !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.ERR); else passed++;
        RST = 1'b0;
        step();
    endtask

    task automatic test_full_load();
        int lat, gaps;
        logic b, e;
        // VALID bits in IDLE must be ignored
        bus.VALID = 1'b1;
        bus.DIN   = 1'b0;
        repeat (3) step();
        bus.VALID = 1'b0;
        total++; if (bus.BUSY !== 1'b0) $display("FAIL idle_busy got=%b exp=0", bus.BUSY); else passed++;
        build(0, 8'd2, FA, FB, 1'b1, 1'b1, 1'b0);
        load(0, -1, lat, gaps, b, e);
        total++; if (b !== 1'b1) $display("FAIL busy_rise got=%b exp=1", b); else passed++;
        total++; if (lat !== MIN_LAT) $display("FAIL full_latency got=%0d exp=%0d", lat, MIN_LAT); else passed++;
        total++; if (bus.DONE !== 1'b1) $display("FAIL full_done got=%b exp=1", bus.DONE); else passed++;
        total++; if (bus.BUSY !== 1'b0) $display("FAIL full_busy_fall got=%b exp=0", bus.BUSY); else passed++;
        total++; if (bus.ERR !== 1'b0) $display("FAIL full_err got=%b exp=0", bus.ERR); else passed++;
        total++; if (bus.CFG !== {FB, FA}) $display("FAIL full_cfg got=%h exp=%h", bus.CFG, {FB, FA}); else passed++;
    endtask

    task automatic test_gaps();
        int lat, gaps;
        logic b, e;
        pulse_reset();
        total++; if (bus.CFG !== DEF2) $display("FAIL gaps_precfg got=%h exp=%h", bus.CFG, DEF2); else passed++;
        build(4, 8'd2, FA, FB, 1'b1, 1'b1, 1'b0);
        load(1, -1, lat, gaps, b, e);
        total++; if (lat !== MIN_LAT + 4 + gaps) $display("FAIL gaps_latency got=%0d exp=%0d", lat, MIN_LAT + 4 + gaps); else passed++;
        total++; if (bus.DONE !== 1'b1) $display("FAIL gaps_done got=%b exp=1", bus.DONE); else passed++;
        total++; if (bus.CFG !== {FB, FA}) $display("FAIL gaps_cfg got=%h exp=%h", bus.CFG, {FB, FA}); else passed++;
    endtask

    task automatic test_len_err();
        logic [7:0] lens [3];
        lens = '{8'd3, 8'd0, 8'd1};
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            build(0, lens[k], FA, FB, 1'b1, 1'b1, 1'b0);
            bus.START = 1'b1;
            step();
            bus.START = 1'b0;
            for (int i = 0; i < 12; i++) begin
                bus.VALID = 1'b1;
                bus.DIN   = q[i];
                step();
            end
            bus.VALID = 1'b0;
            total++; if (bus.ERR !== 1'b0 || bus.BUSY !== 1'b1) $display("FAIL len_err_early len=%0d err=%b busy=%b exp err=0 busy=1", lens[k], bus.ERR, bus.BUSY); else passed++;
            step();
            total++; if (bus.ERR !== 1'b1 || bus.BUSY !== 1'b0) $display("FAIL len_err len=%0d err=%b busy=%b exp err=1 busy=0", lens[k], bus.ERR, bus.BUSY); else passed++;
            total++; if (bus.CFG !== DEF2) $display("FAIL len_err_cfg len=%0d got=%h exp=%h", lens[k], bus.CFG, DEF2); else passed++;
        end
    endtask

    task automatic test_stop_err();
        int lat, gaps;
        logic b, e;
        build(0, 8'd2, FA, FB, 1'b1, 1'b1, 1'b0);
        load(0, -1, lat, gaps, b, e);
        total++; if (bus.CFG !== {FB, FA}) $display("FAIL stop_pre_cfg got=%h exp=%h", bus.CFG, {FB, FA}); else passed++;
        build(0, 8'd2, FC, FD, 1'b1, 1'b0, 1'b0);
        load(0, -1, lat, gaps, b, e);
        total++; if (bus.ERR !== 1'b1) $display("FAIL stop_err got=%b exp=1", bus.ERR); else passed++;
        total++; if (lat !== MIN_LAT) $display("FAIL stop_err_latency got=%0d exp=%0d", lat, MIN_LAT); else passed++;
        total++; if (bus.DONE !== 1'b0) $display("FAIL stop_err_done got=%b exp=0", bus.DONE); else passed++;
        total++; if (bus.CFG !== {FB, FA}) $display("FAIL stop_err_cfg got=%h exp=%h", bus.CFG, {FB, FA}); else passed++;
        // second START pulse mid-frame must not restart the load
        build(0, 8'd2, FC, FD, 1'b1, 1'b1, 1'b0);
        load(0, 20, lat, gaps, b, e);
        total++; if (e !== 1'b0) $display("FAIL start_clears_err got=%b exp=0", e); else passed++;
        total++; if (lat !== MIN_LAT) $display("FAIL busy_start_latency got=%0d exp=%0d", lat, MIN_LAT); else passed++;
        total++; if (bus.DONE !== 1'b1) $display("FAIL busy_start_done got=%b exp=1", bus.DONE); else passed++;
        total++; if (bus.CFG !== {FD, FC}) $display("FAIL busy_start_cfg got=%h exp=%h", bus.CFG, {FD, FC}); else passed++;
    endtask

    task automatic test_rst_mid();
        int lat, gaps;
        logic b, e;
        build(0, 8'd2, FC, FA, 1'b1, 1'b1, 1'b0);
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        for (int i = 0; i < 12 + FT + 18; i++) begin
            bus.VALID = 1'b1;
            bus.DIN   = q[i];
            step();
        end
        bus.VALID = 1'b0;
        total++; if (bus.BUSY !== 1'b1) $display("FAIL rst_mid_busy_before got=%b exp=1", bus.BUSY); else passed++;
        RST = 1'b1;
        #2;
        total++; if (bus.CFG !== DEF2) $display("FAIL rst_mid_cfg got=%h exp=%h", bus.CFG, DEF2); else passed++;
        total++; if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.ERR !== 1'b0) $display("FAIL rst_mid_flags busy=%b done=%b err=%b exp all 0", bus.BUSY, bus.DONE, bus.ERR); else passed++;
        step();
        RST = 1'b0;
        step();
        build(0, 8'd2, FD, FB, 1'b1, 1'b1, 1'b0);
        load(0, -1, lat, gaps, b, e);
        total++; if (bus.CFG !== {FB, FD}) $display("FAIL rst_reload_cfg got=%h exp=%h", bus.CFG, {FB, FD}); else passed++;
    endtask

`ifdef CLB_CFG_PARITY_EN
    task automatic test_parity();
        int lat, gaps;
        logic b, e;
        pulse_reset();
        build(0, 8'd2, FA, FB, 1'b1, 1'b1, 1'b1);
        load(0, -1, lat, gaps, b, e);
        total++; if (bus.ERR !== 1'b1 || bus.DONE !== 1'b0) $display("FAIL parity_bad err=%b done=%b exp err=1 done=0", bus.ERR, bus.DONE); else passed++;
        total++; if (bus.CFG !== DEF2) $display("FAIL parity_bad_cfg got=%h exp=%h", bus.CFG, DEF2); else passed++;
        build(0, 8'd2, FA, FB, 1'b1, 1'b1, 1'b0);
        load(0, -1, lat, gaps, b, e);
        total++; if (bus.DONE !== 1'b1 || lat !== MIN_LAT) $display("FAIL parity_good done=%b lat=%0d exp done=1 lat=%0d", bus.DONE, lat, MIN_LAT); else passed++;
        total++; if (bus.CFG !== {FB, FA}) $display("FAIL parity_good_cfg got=%h exp=%h", bus.CFG, {FB, FA}); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_gaps();
        test_len_err();
        test_stop_err();
        test_rst_mid();
`ifdef CLB_CFG_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
